// File: rtl/status_flag_unit_if.sv
// Status flag unit interface: the ID/EX signals that reach the NZCV status unit.
// The master side is the pipeline; the slave side is status_flag_unit.
interface status_flag_unit_if #(
   parameter int CW = 2
);
   logic          freeze;
   logic          flush;
   logic          id_valid;
   logic          id_s;
   logic [3:0]    id_cond;
   logic          ex_s_commit;
   logic [3:0]    alu_flags;
   logic [3:0]    stat_reg;
   logic          flag_hazard;
   logic [CW-1:0] pending_cnt;
   logic          err_underflow;

   modport master (
      output freeze, flush, id_valid, id_s, id_cond, ex_s_commit, alu_flags,
      input  stat_reg, flag_hazard, pending_cnt, err_underflow
   );

   modport slave (
      input  freeze, flush, id_valid, id_s, id_cond, ex_s_commit, alu_flags,
      output stat_reg, flag_hazard, pending_cnt, err_underflow
   );
endinterface

// File: rtl/status_flag_unit.sv
// NZCV status register with in-flight flag-writer tracking and the ID-stage
// flag hazard. Flags are stored {z,c,n,v} (bit3=z .. bit0=v).
module status_flag_unit #(
   parameter int BYPASS        = 1,
   parameter int IN_FLIGHT_MAX = 2,
   parameter int CW            = 2
) (
   input logic               clk,
   input logic               rst_n,
   status_flag_unit_if.slave sif
);
   localparam logic [CW-1:0] CNT_MAX = CW'(IN_FLIGHT_MAX);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic          BYP     = (BYPASS != 0);

   logic [3:0]    flags_q;
   logic [CW-1:0] cnt_q, cnt_nxt;
   logic          err_q, err_nxt;
   logic          rd_flags, rd_hz, cap_hz, hazard, issue;

   // AL and the 1111 encoding are unconditional; everything else reads flags.
   assign rd_flags = (sif.id_cond != 4'b1110) && (sif.id_cond != 4'b1111);

   // With bypass, the last outstanding writer committing now is forwarded, so
   // the reader need not wait for it.
   assign rd_hz  = rd_flags && (cnt_q != '0) &&
                   !(BYP && (cnt_q == CNT_ONE) && sif.ex_s_commit);
   // Tracker full: a new writer can only enter if one leaves this cycle.
   assign cap_hz = sif.id_s && (cnt_q == CNT_MAX) && !sif.ex_s_commit;
   assign hazard = sif.id_valid && (rd_hz || cap_hz);
   assign issue  = sif.id_valid && sif.id_s && !sif.freeze && !hazard && !sif.flush;

   // Pending-writer count and sticky underflow; flush wins, then issue/commit.
   always_comb begin
      cnt_nxt = cnt_q;
      err_nxt = err_q;
      if (sif.flush) begin
         cnt_nxt = '0;
      end else if (issue && sif.ex_s_commit) begin
         cnt_nxt = cnt_q;
      end else if (issue) begin
         cnt_nxt = cnt_q + CNT_ONE;
      end else if (sif.ex_s_commit) begin
         if (cnt_q != '0) cnt_nxt = cnt_q - CNT_ONE;
         else             err_nxt = 1'b1;
      end
   end

   // State registers; commits update flags regardless of freeze or flush since
   // the EX instruction is older than whatever caused them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags_q <= 4'b0000;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (sif.ex_s_commit) flags_q <= sif.alu_flags;
         cnt_q <= cnt_nxt;
         err_q <= err_nxt;
      end
   end

   generate
      if (BYPASS != 0) begin : g_byp
         assign sif.stat_reg = sif.ex_s_commit ? sif.alu_flags : flags_q;
      end else begin : g_nobyp
         assign sif.stat_reg = flags_q;
      end
   endgenerate

   assign sif.flag_hazard   = hazard;
   assign sif.pending_cnt   = cnt_q;
   assign sif.err_underflow = err_q;
endmodule

// File: doc/status_flag_unit.md
Name: status_flag_unit

Overview:
- Holds the architectural NZCV status register.
- Feeds the 4-bit status word to the ID-stage condition check.
- Commits ALU flags from the EX stage when an S-suffixed instruction retires through EX.
- Tracks flag-setting instructions in flight between ID and EX. Raises a flag hazard that stalls ID when a conditional instruction would otherwise read stale flags.

Parameters:
- BYPASS, 1: when 1, stat_reg forwards alu_flags combinationally in the cycle ex_s_commit=1. When 0, new flags are visible the cycle after commit.
- IN_FLIGHT_MAX, 2: maximum number of tracked flag writers between ID issue and EX commit. Must be ≥1.
- CW, 2: pending counter width. Must equal clog2(IN_FLIGHT_MAX+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- freeze  in  1  pipeline stall. Blocks new issue tracking only.
- flush  in  1  branch-taken flush. Kills all tracked in-flight writers.
- id_valid  in  1  valid instruction in ID.
- id_s  in  1  S bit of the ID instruction.
- id_cond  in  4  condition field of the ID instruction.
- ex_s_commit  in  1  EX instruction writes flags this cycle.
- alu_flags  in  4  new flags {z,c,n,v}: bit3=z, bit2=c, bit1=n, bit0=v.
- stat_reg  out  4  current status {z,c,n,v}, same bit order, to the condition check.
- flag_hazard  out  1  ID must stall. Combinational.
- pending_cnt  out  CW  number of tracked in-flight flag writers.
- err_underflow  out  1  sticky: a commit occurred with pending_cnt=0 and no same-cycle issue.

Behaviour:
- Reset: when rst_n=0 at a rising edge, flags←4'b0000, pending_cnt←0, err_underflow←0. Reset has priority over all other inputs, including mid-stall and mid-flush.
- Flag register:
  - On a rising edge with ex_s_commit=1, flags←alu_flags.
  - Commit is not gated by freeze or flush, because the EX instruction is older than the flush source.
- stat_reg output:
  - BYPASS=1: stat_reg = ex_s_commit ? alu_flags : flags.
  - BYPASS=0: stat_reg = flags.
- Flag-reading instruction: id_cond ∉ {4'b1110 (AL), 4'b1111}. AL and 4'b1111 read no flags.
- Hazard: flag_hazard = id_valid & (rd_hz | cap_hz), where:
  - rd_hz = reads flags & pending_cnt≠0 & ~(BYPASS & pending_cnt==1 & ex_s_commit).
  - cap_hz = id_s & pending_cnt==IN_FLIGHT_MAX & ~ex_s_commit.
- Issue event: issue = id_valid & id_s & ~freeze & ~flag_hazard & ~flush.
- Counter next-state, in priority order:
  - flush=1: pending_cnt←0. A same-cycle commit still updates flags and does not set err_underflow.
  - issue & ex_s_commit: pending_cnt unchanged.
  - issue only: pending_cnt+1. It never exceeds IN_FLIGHT_MAX, because cap_hz blocks the issue.
  - ex_s_commit only: pending_cnt−1 if nonzero. If zero, it stays 0 and err_underflow←1.
  - otherwise: pending_cnt holds.
- Freeze: blocks issue only. Commits still decrement the counter and update flags.
- Latency:
  - Flag update to stat_reg: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Hazard release: the same cycle as the last pending commit with BYPASS=1, the next cycle with BYPASS=0.
- err_underflow: cleared only by reset.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while ex_s_commit=1 and alu_flags=4'b1111 -> stat_reg=0000, pending_cnt=0, err_underflow=0. Release rst_n; the next commit of 4'b1010 -> stat_reg=1010.
- Bypass forwarding (BYPASS=1): issue id_s=1 (pending_cnt=1). Next cycle present id_cond=EQ (4'b0000) with ex_s_commit=1, alu_flags=1000 -> flag_hazard=0 and stat_reg=1000 in that cycle. Same sequence with BYPASS=0 -> flag_hazard=1 for one cycle, then 0 with stat_reg=1000.
- Capacity: issue two S instructions back-to-back with no commit -> pending_cnt=2. A third id_s=1 with id_cond=AL -> flag_hazard=1, pending_cnt stays 2. Add ex_s_commit=1 -> hazard drops, pending_cnt stays 2.
- Flush: pending_cnt=2, assert flush with ex_s_commit=1, alu_flags=0100 -> pending_cnt=0, stat_reg=0100 next cycle, err_underflow=0.
- Freeze: pending_cnt=1, freeze=1, id_s=1 with id_cond=AL, ex_s_commit=1 -> pending_cnt=0, no increment. Deassert freeze -> pending_cnt=1.
- Underflow: pending_cnt=0, ex_s_commit=1 with no issue -> err_underflow=1 and stays 1 through 10 idle cycles. Flags still updated. Only rst_n=0 clears it.
